sample_queue: RTL

- Circular dual-channel sample buffer that sits directly upstream of the per-band FIR filters.
- Stores incoming left/right audio samples as they arrive.
- On each new sample (once primed), replays the most recent READ_LEN samples, oldest first, one per clock, while asserting sequencing.
- The FIR filters reset their coefficient address and accumulators on the rising edge of sequencing and multiply-accumulate one tap per cycle.

---
 rtl/sample_queue_pkg.sv | 15 +
 rtl/dualport_ram_dw.sv | 35 +++
 rtl/sample_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sample_queue_pkg.sv
// Shared definitions for the sample_queue circular replay buffer:
// default geometry and the controller state encoding.
package sample_queue_pkg;

  localparam int SQ_DW       = 16;
  localparam int SQ_DEPTH    = 1024;
  localparam int SQ_READ_LEN = 1021;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } sq_state_e;

endpackage

// File: rtl/dualport_ram_dw.sv
// DEPTH x DW memory with one write port and one synchronous read port.
// The read register resets to zero and holds its value when no read is issued.
module dualport_ram_dw #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // registered read port, holds the last value read between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_queue.sv
// sample_queue: dual-channel circular buffer that replays the newest READ_LEN samples,
// oldest first, after every new sample. Build macro SAMPLE_QUEUE_ZERO_FILL_EN zero-primes the window at reset.
module sample_queue
  import sample_queue_pkg::*;
#(
  parameter int DW       = SQ_DW,
  parameter int DEPTH    = SQ_DEPTH,
  parameter int READ_LEN = SQ_READ_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_smpl,
  input  logic [DW-1:0] lft_smpl,
  input  logic [DW-1:0] rght_smpl,
  output logic [DW-1:0] lft_out,
  output logic [DW-1:0] rght_out,
  output logic          sequencing,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(READ_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(READ_LEN - 1);

  sq_state_e     state_r;
  sq_state_e     state_nxt;
  logic [AW-1:0] new_ptr_r;
  logic [AW-1:0] old_ptr_r;
  logic [KW-1:0] k_r;
  logic          seq_r;
  logic          overrun_r;

  logic          accept_s;
  logic          clr_busy_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_addr_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_lft_s;
  logic [DW-1:0] wr_rght_s;

`ifdef SAMPLE_QUEUE_ZERO_FILL_EN
  localparam sq_state_e     RST_STATE   = IDLE;
  localparam logic [AW-1:0] RST_NEW_PTR = AW'(READ_LEN - 1);
  localparam logic [AW-1:0] CLR_LAST    = AW'(READ_LEN - 2);

  logic [AW-1:0] clr_addr_r;
  logic          clr_busy_r;

  // walk entries 0..READ_LEN-2 writing zeros after reset; inputs are ignored meanwhile
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_r <= '0;
      clr_busy_r <= 1'b1;
    end else if (clr_busy_r) begin
      clr_addr_r <= clr_addr_r + AW'(1);
      if (clr_addr_r == CLR_LAST) begin
        clr_busy_r <= 1'b0;
      end
    end
  end

  assign clr_busy_s = clr_busy_r;
  assign wr_en_s    = accept_s | clr_busy_r;
  assign wr_addr_s  = clr_busy_r ? clr_addr_r : new_ptr_r;
  assign wr_lft_s   = clr_busy_r ? '0 : lft_smpl;
  assign wr_rght_s  = clr_busy_r ? '0 : rght_smpl;
`else
  localparam sq_state_e     RST_STATE   = FILL;
  localparam logic [AW-1:0] RST_NEW_PTR = '0;
  localparam int            FW          = $clog2(READ_LEN + 1);
  localparam logic [FW-1:0] FILL_LAST   = FW'(READ_LEN - 1);

  logic [FW-1:0] fill_cnt_r;

  // count samples stored while priming the window
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_r <= '0;
    end else if (accept_s && (state_r == FILL)) begin
      fill_cnt_r <= fill_cnt_r + FW'(1);
    end
  end

  assign clr_busy_s = 1'b0;
  assign wr_en_s    = accept_s;
  assign wr_addr_s  = new_ptr_r;
  assign wr_lft_s   = lft_smpl;
  assign wr_rght_s  = rght_smpl;
`endif

  // next state, write acceptance and read issue; the read for beat k is issued one cycle early
  always_comb begin
    state_nxt = state_r;
    accept_s  = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = old_ptr_r;
    case (state_r)
      FILL: begin
`ifdef SAMPLE_QUEUE_ZERO_FILL_EN
        state_nxt = IDLE;
`else
        if (wrt_smpl) begin
          accept_s = 1'b1;
          if (fill_cnt_r == FILL_LAST) begin
            rd_en_s   = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = FILL;
          end
        end else begin
          state_nxt = FILL;
        end
`endif
      end
      IDLE: begin
        if (wrt_smpl && !clr_busy_s) begin
          accept_s  = 1'b1;
          rd_en_s   = 1'b1;
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (k_r == K_LAST) begin
          state_nxt = IDLE;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = old_ptr_r + AW'(k_r) + AW'(1);
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt = RST_STATE;
      end
    endcase
  end

  // state register, pointers, burst index and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RST_STATE;
      new_ptr_r <= RST_NEW_PTR;
      old_ptr_r <= '0;
      k_r       <= '0;
      seq_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      seq_r   <= (state_nxt == READ);
      if (accept_s) begin
        new_ptr_r <= new_ptr_r + AW'(1);
      end
      if (state_r == READ) begin
        if (wrt_smpl) begin
          overrun_r <= 1'b1;
        end
        if (k_r == K_LAST) begin
          k_r       <= '0;
          old_ptr_r <= old_ptr_r + AW'(1);
        end else begin
          k_r <= k_r + KW'(1);
        end
      end
    end
  end

  assign sequencing = seq_r;
  assign overrun    = overrun_r;

  dualport_ram_dw #(.DW(DW), .DEPTH(DEPTH)) u_ram_lft (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_lft_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (lft_out)
  );

  dualport_ram_dw #(.DW(DW), .DEPTH(DEPTH)) u_ram_rght (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_rght_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rght_out)
  );

endmodule
